mult_div_unit: RTL and testbench

Multiply/divide unit for the EX stage of the 5-stage MIPS pipeline. It sits beside the ALU, upstream of the EX/MEM register. It executes mult/multu/div/divu over several cycles with a busy counter, owns the HI/LO registers, and serves mthi/mtlo/mfhi/mflo. Its read data joins the EX result mux that feeds ALUOut into EX/MEM. Its busy output drives the ID-stage stall logic.

---
 rtl/mips_defs.sv | 21 ++
 rtl/md_calc.sv | 43 ++++
 rtl/mult_div_unit.sv | 111 +++++++++++
 tb/tb_mult_div_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: multiply/divide opcodes, read selects and latencies.
package mips_defs;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    localparam logic MD_RD_LO = 1'b0;
    localparam logic MD_RD_HI = 1'b1;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_calc.sv
// Combinational datapath: 64-bit product plus quotient/remainder, signed or unsigned.
module md_calc (
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] prod,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        div_zero
);

    logic overflow;

    assign div_zero = (b == 32'd0);
    // The one signed quotient that does not fit in 32 bits.
    assign overflow = is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // NOTE: every output gets a default before the branches so no path infers a latch.
    always_comb begin
        prod = 64'd0;
        quot = 32'd0;
        rem  = 32'd0;
        if (is_signed) begin
            prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        end else begin
            prod = {32'd0, a} * {32'd0, b};
        end
        if (div_zero) begin
            quot = 32'd0;
            rem  = 32'd0;
        end else if (overflow) begin
            quot = 32'h8000_0000;
            rem  = 32'd0;
        end else if (is_signed) begin
            quot = $signed(a) / $signed(b);
            rem  = $signed(a) % $signed(b);
        end else begin
            quot = a / b;
            rem  = a % b;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, models multi-cycle latency with a busy counter.
module mult_div_unit
    import mips_defs::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic [31:0] md_a,
    input  logic [31:0] md_b,
    input  logic        md_rd_sel,
    output logic [31:0] md_out,
    output logic        md_busy
);

    localparam int CNT_W = 4;

    md_op_e           op;
    logic [31:0]      hi, lo, hi_pend, lo_pend;
    logic [31:0]      hi_n, lo_n, hi_pend_n, lo_pend_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             pend_we, pend_we_n;
    logic             accept;
    logic [63:0]      prod;
    logic [31:0]      quot, rem;
    logic             div_zero;

    assign op      = md_op_e'(md_op);
    assign md_busy = (cnt != '0);
    // The commit edge (cnt==1) doubles as an accept edge for back-to-back issue.
    assign accept  = (cnt <= CNT_W'(1));
    assign md_out  = (md_rd_sel == MD_RD_HI) ? hi : lo;

    md_calc u_calc (
        .is_signed (op == MD_MULT || op == MD_DIV),
        .a         (md_a),
        .b         (md_b),
        .prod      (prod),
        .quot      (quot),
        .rem       (rem),
        .div_zero  (div_zero)
    );

    always_comb begin
        hi_n      = hi;
        lo_n      = lo;
        hi_pend_n = hi_pend;
        lo_pend_n = lo_pend;
        cnt_n     = cnt;
        pend_we_n = pend_we;
        if (cnt != '0) begin
            cnt_n = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                if (pend_we) begin
                    hi_n = hi_pend;
                    lo_n = lo_pend;
                end
                pend_we_n = 1'b0;
            end
        end
        if (accept) begin
            case (op)
                MD_MULT, MD_MULTU: begin
                    hi_pend_n = prod[63:32];
                    lo_pend_n = prod[31:0];
                    cnt_n     = CNT_W'(MULT_CYCLES);
                    pend_we_n = 1'b1;
                end
                MD_DIV, MD_DIVU: begin
                    hi_pend_n = rem;
                    lo_pend_n = quot;
                    cnt_n     = CNT_W'(DIV_CYCLES);
                    pend_we_n = !div_zero;
                end
                MD_MTHI: hi_n = md_a;
                MD_MTLO: lo_n = md_a;
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            hi_pend <= '0;
            lo_pend <= '0;
            cnt     <= '0;
            pend_we <= 1'b0;
        end else begin
            hi      <= hi_n;
            lo      <= lo_n;
            hi_pend <= hi_pend_n;
            lo_pend <= lo_pend_n;
            cnt     <= cnt_n;
            pend_we <= pend_we_n;
        end
    end

    // Stall logic should never let an op reach us mid-operation; flag it if one does.
    always @(posedge clk) begin
        if (!reset && cnt > CNT_W'(1)) begin
            assert (op == MD_NONE || op == MD_RSVD)
            else $warning("md_op %0d ignored while busy", md_op);
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, scoreboard and multi-cycle corner cases.
module tb_mult_div_unit;
    import mips_defs::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  md_op = MD_NONE;
    logic [31:0] md_a = '0;
    logic [31:0] md_b = '0;
    logic        md_rd_sel = 1'b0;
    logic [31:0] md_out;
    logic        md_busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];

    mult_div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .md_op     (md_op),
        .md_a      (md_a),
        .md_b      (md_b),
        .md_rd_sel (md_rd_sel),
        .md_out    (md_out),
        .md_busy   (md_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic read_reg(input logic sel, output logic [31:0] v);
        md_rd_sel = sel;
        #1;
        v = md_out;
    endtask

    task automatic check_hilo(input string name, input exp_t e);
        logic [31:0] v;
        read_reg(MD_RD_HI, v);
        check({name, " HI"}, v, e.hi);
        read_reg(MD_RD_LO, v);
        check({name, " LO"}, v, e.lo);
    endtask

    task automatic pop_and_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            check_hilo(name, e);
        end
    endtask

    // Issues op at the next edge, waits for busy to drop (bounded), returns busy cycles.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        @(negedge clk);
        md_op = op;
        md_a  = a;
        md_b  = b;
        @(negedge clk);
        md_op = MD_NONE;
        n = 0;
        while (md_busy && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic write_reg(input logic [2:0] op, input logic [31:0] v);
        @(negedge clk);
        md_op = op;
        md_a  = v;
        @(negedge clk);
        md_op = MD_NONE;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        logic [31:0] v;
        exp_t        e;

        vecs[0] = '{MD_MULT,  32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};
        vecs[1] = '{MD_MULTU, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 5};
        vecs[2] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
        vecs[3] = '{MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5};
        vecs[4] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[5] = '{MD_DIVU,  32'd7,         32'd2,        32'd1,         32'd3,         10};
        vecs[6] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 10};
        vecs[7] = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 10};
        vecs[8] = '{MD_DIVU,  32'hFFFF_FFFF, 32'd10,       32'd5,         32'h1999_9999, 10};

        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset busy", {31'd0, md_busy}, 32'd0);
        e = '{32'd0, 32'd0};
        check_hilo("reset", e);

        // Vector table through the scoreboard
        for (int i = 0; i < 9; i++) begin
            sb.push_back('{vecs[i].hi, vecs[i].lo});
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
            check($sformatf("vec%0d busy cycles", i), n, vecs[i].cyc);
            pop_and_check($sformatf("vec%0d", i));
        end

        // Divide by zero leaves preloaded HI/LO untouched
        write_reg(MD_MTHI, 32'h11);
        write_reg(MD_MTLO, 32'h22);
        sb.push_back('{32'h11, 32'h22});
        run_op(MD_DIV, 32'd5, 32'd0, n);
        check("div0 busy cycles", n, 10);
        pop_and_check("div0");

        // Back-to-back: ignored MTLO while busy, DIV issued on the commit edge
        sb.push_back('{32'd0, 32'd12});
        sb.push_back('{32'd2, 32'd14});
        @(negedge clk);
        md_op = MD_MULT;
        md_a  = 32'd3;
        md_b  = 32'd4;
        n = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!md_busy) break;
            n++;
            md_op = MD_NONE;
            case (c)
                1: begin md_op = MD_MTLO; md_a = 32'h55; end
                5: begin md_op = MD_DIV; md_a = 32'd100; md_b = 32'd7; end
                6: pop_and_check("b2b mult");
                default: ;
            endcase
        end
        md_op = MD_NONE;
        check("b2b busy cycles", n, 15);
        pop_and_check("b2b div");

        // Read path: same-cycle read sees old HI, next cycle sees new HI
        @(negedge clk);
        md_op = MD_MTHI;
        md_a  = 32'hABCD;
        read_reg(MD_RD_HI, v);
        check("mthi same cycle", v, 32'd2);
        @(negedge clk);
        md_op = MD_NONE;
        read_reg(MD_RD_HI, v);
        check("mthi next cycle", v, 32'hABCD);

        // Reset mid-DIV aborts without commit
        @(negedge clk);
        md_op = MD_DIV;
        md_a  = 32'd100;
        md_b  = 32'd3;
        @(negedge clk);
        md_op = MD_NONE;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid reset busy", {31'd0, md_busy}, 32'd0);
        e = '{32'd0, 32'd0};
        check_hilo("mid reset", e);
        repeat (15) @(negedge clk);
        check("post reset busy", {31'd0, md_busy}, 32'd0);
        check_hilo("post reset", e);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
